// File: rtl/subcarrier_mapper.sv
// OFDM subcarrier mapper: reorders N_ACTIVE frequency-ordered QAM symbols into FFT_SIZE IFFT bins.
// Optional macro SUBCARRIER_MAPPER_SYM_CNT_EN adds a 0..13 symbol index output (sym_idx).
module subcarrier_mapper #(
    parameter int WIDTH    = 26,
    parameter int FFT_SIZE = 2048,
    parameter int N_ACTIVE = 1200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in_r,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out_r,
    output logic [WIDTH-1:0] data_out_i,
    output logic             VALID_R,
    output logic             VALID_I,
    output logic             sym_start
`ifdef SUBCARRIER_MAPPER_SYM_CNT_EN
    ,
    output logic [3:0]       sym_idx
`endif
);

    localparam int H  = N_ACTIVE / 2;
    localparam int BW = (FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1;
    localparam int LW = (H > 1) ? $clog2(H) : 1;
    localparam logic [BW-1:0] BIN_POS_LAST   = BW'(H);
    localparam logic [BW-1:0] BIN_GUARD_LAST = BW'(FFT_SIZE - H - 1);
    localparam logic [BW-1:0] BIN_LAST       = BW'(FFT_SIZE - 1);
    localparam logic [LW-1:0] LD_LAST        = LW'(H - 1);

    typedef enum logic [2:0] {
        LOAD_NEG,
        OUT_DC,
        OUT_POS,
        OUT_GUARD,
        OUT_NEG
    } state_t;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_IN,
        SEL_BUF
    } dsel_t;

    state_t               r_state, w_next;
    dsel_t                w_dsel;
    logic [BW-1:0]        r_bin;
    logic [LW-1:0]        r_ld;
    logic [LW-1:0]        w_ld_inc;
    logic [LW-1:0]        w_addr;
    logic                 w_ld_last;
    logic                 r_live;
    logic                 w_ready;
    logic                 w_fire;
    logic                 w_we;
    logic                 w_vld;
    logic                 w_sop;
    logic [2*WIDTH-1:0]   r_buf [H];
    logic [2*WIDTH-1:0]   r_rd;

    assign w_ld_last = (r_ld == LD_LAST);
    assign w_ld_inc  = w_ld_last ? '0 : r_ld + 1'b1;
    assign w_fire    = in_valid && w_ready;
    assign w_we      = w_fire && (r_state == LOAD_NEG);
    // During OUT_NEG the buffer is read one entry ahead; during OUT_GUARD r_ld is 0,
    // so entry 0 is already in r_rd when the first negative bin is due.
    assign w_addr    = (r_state == OUT_NEG) ? w_ld_inc : r_ld;
    assign in_ready  = w_ready;

    // r_live holds in_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_live <= 1'b0;
        else      r_live <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= LOAD_NEG;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_vld   = 1'b0;
        w_sop   = 1'b0;
        w_dsel  = SEL_ZERO;
        case (r_state)
            LOAD_NEG: begin
                w_ready = r_live;
                if (w_fire && w_ld_last) w_next = OUT_DC;
            end
            OUT_DC: begin
                w_vld  = 1'b1;
                w_sop  = 1'b1;
                w_next = OUT_POS;
            end
            OUT_POS: begin
                w_ready = r_live;
                w_vld   = w_fire;
                w_dsel  = SEL_IN;
                if (w_fire && r_bin == BIN_POS_LAST) w_next = OUT_GUARD;
            end
            OUT_GUARD: begin
                w_vld = 1'b1;
                if (r_bin == BIN_GUARD_LAST) w_next = OUT_NEG;
            end
            OUT_NEG: begin
                w_vld  = 1'b1;
                w_dsel = SEL_BUF;
                if (r_bin == BIN_LAST) w_next = LOAD_NEG;
            end
            default: w_next = LOAD_NEG;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin <= '0;
            r_ld  <= '0;
        end else begin
            case (r_state)
                LOAD_NEG:  if (w_fire) r_ld <= w_ld_inc;
                OUT_DC:    r_bin <= BW'(1);
                OUT_POS:   if (w_fire) r_bin <= r_bin + 1'b1;
                OUT_GUARD: r_bin <= r_bin + 1'b1;
                OUT_NEG: begin
                    r_ld  <= w_ld_inc;
                    r_bin <= (r_bin == BIN_LAST) ? '0 : r_bin + 1'b1;
                end
                default: begin
                    r_bin <= '0;
                    r_ld  <= '0;
                end
            endcase
        end
    end

    // Single-port buffer: writes only in LOAD_NEG, reads only otherwise
    always_ff @(posedge clk) begin
        if (w_we) r_buf[w_addr] <= {data_in_r, data_in_i};
        else      r_rd          <= r_buf[w_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_r <= '0;
            data_out_i <= '0;
            VALID_R    <= 1'b0;
            VALID_I    <= 1'b0;
            sym_start  <= 1'b0;
        end else begin
            VALID_R   <= w_vld;
            VALID_I   <= w_vld;
            sym_start <= w_sop;
            case (w_dsel)
                SEL_IN: begin
                    data_out_r <= data_in_r;
                    data_out_i <= data_in_i;
                end
                SEL_BUF: begin
                    data_out_r <= r_rd[2*WIDTH-1:WIDTH];
                    data_out_i <= r_rd[WIDTH-1:0];
                end
                default: begin
                    data_out_r <= '0;
                    data_out_i <= '0;
                end
            endcase
        end
    end

`ifdef SUBCARRIER_MAPPER_SYM_CNT_EN
    logic r_seen;

    // Index advances on the same edge sym_start is raised, so it is constant across a symbol
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seen  <= 1'b0;
            sym_idx <= '0;
        end else if (w_sop) begin
            r_seen <= 1'b1;
            if (r_seen) sym_idx <= (sym_idx == 4'd13) ? 4'd0 : sym_idx + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_subcarrier_mapper.sv
// Scoreboard bench for subcarrier_mapper: default config and an N_ACTIVE=8/FFT_SIZE=16 config run side by side.
module tb_subcarrier_mapper;

    localparam int W = 26;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit done [2];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int F  = (g == 0) ? 2048 : 16;
        localparam int NA = (g == 0) ? 1200 : 8;
        localparam int H  = NA / 2;

        logic         rst;
        logic [W-1:0] din_r, din_i, dout_r, dout_i;
        logic         in_valid, in_ready, vr, vi, ss;
        logic [63:0]  q [$];
        int           binpos = 0;
        int           n_ss   = 0;
`ifdef SUBCARRIER_MAPPER_SYM_CNT_EN
        logic [3:0]   sidx;
        int           exp_idx = 0;
        bit           seen    = 0;
`endif

        subcarrier_mapper #(.WIDTH(W), .FFT_SIZE(F), .N_ACTIVE(NA)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .data_in_r  (din_r),
            .data_in_i  (din_i),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .data_out_r (dout_r),
            .data_out_i (dout_i),
            .VALID_R    (vr),
            .VALID_I    (vi),
            .sym_start  (ss)
`ifdef SUBCARRIER_MAPPER_SYM_CNT_EN
            ,
            .sym_idx    (sidx)
`endif
        );

        function automatic logic [W-1:0] smp(input int base, input int k, input bit im);
            return im ? W'(-(base + k)) : W'(base + k);
        endfunction

        // Expected {data_r, data_i, sym_start} for bin b of a symbol whose sample k is base+k
        function automatic logic [63:0] exp_bin(input int base, input int b);
            int k = -1;
            if (b == 0) return 64'(1);
            if (b <= H) k = H + b - 1;
            else if (b >= F - H) k = b - (F - H);
            if (k < 0) return 64'(0);
            return 64'({smp(base, k, 1'b0), smp(base, k, 1'b1), 1'b0});
        endfunction

        task automatic send_sym(input int base, input bit gap, input int nsend);
            int nexp = (nsend >= NA) ? F : nsend - H + 1;
            int idx  = 0;
            int wcyc = 0;
            bit tog  = 0;
            bit dc_done = 0;
            for (int b = 0; b < nexp; b++) q.push_back(exp_bin(base, b));
            while (idx < nsend) begin
                @(negedge clk);
                if (idx == H && !dc_done) begin
                    chk("rdy_dc", 64'(in_ready), 64'(0));
                    dc_done = 1;
                end
                if (gap && idx >= H && tog) begin
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1;
                    din_r    = smp(base, idx, 1'b0);
                    din_i    = smp(base, idx, 1'b1);
                end
                if (gap && idx >= H) tog = !tog;
                if (in_valid && in_ready) begin
                    idx++;
                    wcyc = 0;
                end else if (++wcyc > 4 * F) begin
                    chk("stall", 64'(idx), 64'(nsend));
                    break;
                end
            end
            @(negedge clk);
            in_valid = 1'b0;
            if (nsend >= NA) chk("rdy_guard", 64'(in_ready), 64'(0));
        endtask

        task automatic drain();
            for (int c = 0; c < 4 * F && q.size() != 0; c++) @(negedge clk);
            chk("drain", 64'(q.size()), 64'(0));
        endtask

        always @(negedge clk) begin
            if (!rst) begin
                binpos = 0;
`ifdef SUBCARRIER_MAPPER_SYM_CNT_EN
                exp_idx = 0;
                seen    = 0;
`endif
            end else begin
                chk("vld_eq", 64'(vi), 64'(vr));
                if (vr) begin
                    if (binpos >= H && binpos <= F - 2) chk("rdy_busy", 64'(in_ready), 64'(0));
                    if (q.size() == 0) chk("unexpected_bin", 64'(1), 64'(0));
                    else chk($sformatf("cfg%0d_bin%0d", g, binpos), 64'({dout_r, dout_i, ss}), q.pop_front());
                    if (ss) begin
                        n_ss++;
`ifdef SUBCARRIER_MAPPER_SYM_CNT_EN
                        if (seen) exp_idx = (exp_idx == 13) ? 0 : exp_idx + 1;
                        seen = 1;
                        chk("sym_idx", 64'(sidx), 64'(exp_idx));
`endif
                    end
                    binpos = (binpos == F - 1) ? 0 : binpos + 1;
                end else begin
                    chk("ss_idle", 64'(ss), 64'(0));
                    chk("nogap", 64'(binpos > H), 64'(0));
                end
            end
        end

        initial begin
            int n0;
            rst      = 1'b0;
            in_valid = 1'b0;
            din_r    = '0;
            din_i    = '0;
            #1;
            chk("rst_state", 64'({dout_r, dout_i, vr, vi, ss, in_ready}), 64'(0));
            repeat (3) @(negedge clk);
            #2 rst = 1'b1;
            #1 chk("rdy_pre", 64'(in_ready), 64'(0));
            @(negedge clk);
            chk("rdy_rise", 64'(in_ready), 64'(1));

            send_sym(0, 1'b0, NA);
            send_sym(5000, 1'b1, NA);
            drain();

            n0 = n_ss;
            send_sym(10000, 1'b0, NA);
            send_sym(20000, 1'b0, NA);
            send_sym(30000, 1'b0, NA);
            drain();
            chk("sym_start_cnt", 64'(n_ss - n0), 64'(3));

            send_sym(40000, 1'b0, NA * 3 / 4);
            repeat (2) @(negedge clk);
            chk("partial_out", 64'(q.size()), 64'(0));
            #2 rst = 1'b0;
            #1 chk("rst_mid", 64'({dout_r, dout_i, vr, vi, ss, in_ready}), 64'(0));
            repeat (3) @(negedge clk);
            chk("rst_hold", 64'({dout_r, dout_i, vr, vi, ss, in_ready}), 64'(0));
            #2 rst = 1'b1;
            send_sym(50000, 1'b0, NA);
            drain();
            done[g] = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 60000 && !(done[0] && done[1]); c++) @(negedge clk);
        chk("finish", 64'(done[0] && done[1]), 64'(1));
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/subcarrier_mapper.md
SUBCARRIER_MAPPER -- requirements
Module: subcarrier_mapper

Interface
REQ-001 Parameter WIDTH, default 26, is the sample width of each real and imaginary component.
REQ-002 Parameter FFT_SIZE, default 2048, is the IFFT points per OFDM symbol.
REQ-003 Parameter N_ACTIVE, default 1200, is the active subcarriers per symbol; it SHALL be even and below FFT_SIZE.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 data_in_r / data_in_i  input  WIDTH each  QAM symbol in ascending frequency order: lowest negative subcarrier first.
REQ-007 in_valid  input  1  input sample is valid.
REQ-008 in_ready  output  1  mapper accepts a sample this cycle; transfer occurs when in_valid and in_ready are both 1.
REQ-009 data_out_r / data_out_i  output  WIDTH each  mapped bin value in IFFT natural order, for the IFFT input.
REQ-010 VALID_R / VALID_I  output  1 each  output bin valid; both SHALL always be equal.
REQ-011 sym_start  output  1  pulses with bin 0 of each symbol.

Function
REQ-012 Bin map, with H=N_ACTIVE/2:
- bin 0 = DC zero.
- bins 1..H = input samples H..N_ACTIVE-1 (positive half).
- bins H+1..FFT_SIZE-H-1 = zero (guard).
- bins FFT_SIZE-H..FFT_SIZE-1 = input samples 0..H-1 (negative half).
REQ-013 The FSM SHALL have states LOAD_NEG, OUT_DC, OUT_POS, OUT_GUARD, OUT_NEG; a bin counter SHALL be 0..FFT_SIZE-1 and a load counter 0..H-1.
REQ-014 LOAD_NEG:
- in_ready=1.
- Each transfer is written to an H-deep buffer at the load counter.
- No output valid.
- After the H-th transfer, go to OUT_DC.
REQ-015 OUT_DC: one cycle; output zero with valid=1 and sym_start=1; in_ready=0; go to OUT_POS.
REQ-016 OUT_POS:
- in_ready=1.
- Each transfer is output as the next bin with valid=1.
- Cycles with in_valid=0 output valid=0 and do not advance the bin counter.
- After bin H, go to OUT_GUARD.
REQ-017 OUT_GUARD: in_ready=0; output FFT_SIZE-N_ACTIVE-1 consecutive zero bins, valid=1 every cycle; then go to OUT_NEG.
REQ-018 OUT_NEG:
- in_ready=0.
- Output buffer entries 0..H-1 on consecutive cycles, valid=1.
- Prefetch the synchronous buffer read so there are no bubbles at the GUARD-to-NEG boundary.
- After the last entry, go to LOAD_NEG.
REQ-019 Outputs SHALL be registered: a sample transferred in OUT_POS appears on data_out exactly 1 cycle later.
REQ-020 Data SHALL pass unmodified; zero bins SHALL be all-zero in both components.
REQ-021 Consecutive symbols SHALL have no overlap: the next symbol's loading starts only after bin FFT_SIZE-1 is output.
REQ-022 The buffer SHALL be single-port; there are no simultaneous read and write by construction, because LOAD_NEG and OUT_NEG are exclusive.
REQ-023 in_valid while in_ready=0 SHALL be ignored, with no state change and no data loss attributed to the mapper.

Reset
REQ-024 Reset asserted SHALL immediately force:
- state LOAD_NEG;
- all counters 0;
- data_out_r=0, data_out_i=0;
- VALID_R=0, VALID_I=0, sym_start=0;
- in_ready=0 while reset is asserted.
REQ-025 Reset mid-symbol SHALL discard the partial symbol; after release, the first transfer is treated as input sample 0.
REQ-026 in_ready SHALL rise on the first clock after reset release; buffer contents need no reset.

Configuration
REQ-027 Macro SUBCARRIER_MAPPER_SYM_CNT_EN:
- Defined: adds output sym_idx [3:0], reset 0, which increments on each sym_start after the first, wraps 13 to 0, and is stable for the whole symbol.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Verification
REQ-028 Defaults; feed 1200 samples with r=index, i=-index, continuous -> bin0=0; bins 1..600 = 600..1199; bins 601..1447 = 0; bins 1448..2047 = 0..599; 2048 valid bins with no gaps from OUT_DC onward.
REQ-029 Same input with in_valid toggling 1,0 in the positive half -> bins 1..600 correct; valid gaps only in OUT_POS; bin ordering unchanged.
REQ-030 Three back-to-back symbols with distinct data -> sym_start exactly 3 times; each symbol mapped independently; in_ready=0 during DC/GUARD/NEG.
REQ-031 Assert rst after 900 samples of symbol 1, then a fresh 1200-sample symbol -> all outputs 0 during reset; the next output symbol contains only the fresh data.
REQ-032 With SUBCARRIER_MAPPER_SYM_CNT_EN, 15 symbols -> sym_idx 0..13 then 0.
REQ-033 Parameters N_ACTIVE=8, FFT_SIZE=16 -> guard bins 5..11 zero; bins 12..15 = inputs 0..3; bins 1..4 = inputs 4..7.
